operand_tf_ctrl: RTL and testbench
==================================

# operand_tf_ctrl

Sequencing and packing stage that sits directly upstream of the `operand_tf_lane` array. It accepts one MX block per handshake, containing 2·NUM_LANES elements and NUM_LANES shared micro scales. It drives the lanes' `load_input`, `iter_sel` and `we_result` through a fixed even-then-odd pass. It then captures the lane temporal registers into a skid-free output register presented with valid/ready.

## Interface
Parameters:
- NUM_LANES, 8, number of `operand_tf_lane` instances driven.
- ELEM_WIDTH_IN, `operand_tf_pkg::ELEM_WIDTH_IN`, input element width.
- ELEM_WIDTH_OUT, `operand_tf_pkg::ELEM_WIDTH_OUT`, lane result width.
- SCALE_WIDTH, `operand_tf_pkg::SCALE_WIDTH`, micro scale width.

Ports:
- clk  in  1  single clock. All logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input block valid.
- in_ready  out  1  ctrl can accept a block.
- in_elems  in  2·NUM_LANES·ELEM_WIDTH_IN  element k at `[k*ELEM_WIDTH_IN +: ELEM_WIDTH_IN]`.
- in_scales  in  NUM_LANES·SCALE_WIDTH  scale i for lane i.
- lane_load  out  1  broadcast `load_input`.
- lane_iter_sel  out  1  broadcast `iter_sel`.
- lane_we  out  1  broadcast `we_result`.
- lane_elem0 / lane_elem1  out  NUM_LANES·ELEM_WIDTH_IN each  element 2i / 2i+1 to lane i.
- lane_scale  out  NUM_LANES·SCALE_WIDTH  scale i to lane i.
- lane_res0 / lane_res1  in  NUM_LANES·ELEM_WIDTH_OUT each  lane i `res_0_out` / `res_1_out`.
- out_valid  in→out  1  packed result valid (output).
- out_ready  in  1  downstream accepts.
- out_data  out  2·NUM_LANES·ELEM_WIDTH_OUT  result k at `[k*ELEM_WIDTH_OUT +: ELEM_WIDTH_OUT]`.
- busy  out  1  state ≠ IDLE.
- perf_blk_cnt  out  32  blocks delivered (see Configuration).
- perf_stall_cnt  out  32  cycles in DONE blocked by a full output register.

## Operation
- The lane data buses are a combinational slice of `in_elems`/`in_scales`: element 2i goes to lane i `elem_0`, element 2i+1 to lane i `elem_1`.
- FSM states are IDLE, EVEN, ODD and DONE.
- IDLE:
  - `in_ready`=1; `lane_load` = `in_valid`.
  - On `in_valid`, go to EVEN.
- EVEN:
  - `lane_iter_sel`=0, `lane_we`=1.
  - Go to ODD.
- ODD:
  - `lane_iter_sel`=1, `lane_we`=1.
  - Go to DONE.
- DONE:
  - The lane results are now stable.
  - If `out_valid`=0 or `out_ready`=1, load `out_data` from the lane results, set `out_valid`=1, and go to IDLE.
  - Otherwise stay in DONE; this is a stall.
- Packing: `out_data` word 2i = lane i `res0`, word 2i+1 = lane i `res1`. This is a pure bit copy, with no arithmetic and no width change.
- Output handshake:
  - `out_valid` clears on `out_valid & out_ready` unless it is reloaded the same cycle.
  - A reload and a drain in the same cycle leaves `out_valid`=1 with the new data.
  - `out_data` is stable while `out_valid & !out_ready`.
- `in_valid` and the input data are sampled only in IDLE. Input changes after acceptance have no effect.
- In EVEN, ODD and DONE: `in_ready`=0, `lane_load`=0.
- In IDLE and DONE: `lane_iter_sel`=0, `lane_we`=0.

## Timing
- Reset values:
  - State = IDLE.
  - `out_valid`=0, `out_data`=0, `busy`=0, both counters 0.
  - `lane_we`=0, `lane_iter_sel`=0.
  - `in_ready`=1 and `lane_load`=`in_valid` from the first cycle after reset.
- Latency and throughput:
  - Block accepted at cycle T.
  - EVEN at T+1, ODD at T+2, DONE at T+3.
  - `out_valid`=1 at T+4.
  - Next acceptance no earlier than T+4, so throughput is one block per 4 cycles.
- If `rst` is asserted in any state, the next cycle is IDLE with all outputs at reset values. A partially processed block is discarded and the lanes are not re-cleared.
- DONE stall length is unbounded. `perf_stall_cnt` increments once per stalled DONE cycle.
- When `perf_blk_cnt` reaches 2^32−1, it wraps to 0.

## Configuration
- `OPERAND_TF_CTRL_PERF_EN` defined:
  - `perf_blk_cnt` increments on each `out_valid & out_ready`.
  - `perf_stall_cnt` counts as described under Timing.
- `OPERAND_TF_CTRL_PERF_EN` undefined:
  - Both counter ports are tied to 0.
  - No counter flops are synthesized.
  - All other behaviour is identical.

## Test plan
Bench: ctrl plus NUM_LANES=8 `operand_tf_lane`, with a lane multiplier model that computes elem·scale.
- Single block: elements 2i=i+1 and 2i+1=i+17, all scales 3, `in_valid` at cycle 0, `out_ready`=1 → `lane_load`=1 at 0, `iter_sel` 0/1 with `we`=1 at 1/2, `out_valid`=1 at 4, word 2i=3(i+1), word 2i+1=3(i+17).
- Back-to-back: `in_valid` held high for 3 blocks → acceptances at cycles 0, 4, 8; `out_valid` at 4, 8, 12; each block's data correct.
- Backpressure: `out_ready`=0 from cycle 0, second block offered → first output held stable, ctrl sits in DONE from cycle 7, `perf_stall_cnt` grows by 1 per cycle; `out_ready`=1 at cycle 12 → second result valid at 13, `perf_blk_cnt`=1 after that cycle.
- Reset in ODD: `rst` asserted at cycle 2 of a block → cycle 3 is IDLE, `in_ready`=1, `out_valid`=0, no output for that block.
- Input perturbation: `in_elems` changed to all 0xFF at cycle 1 → output still reflects the data sampled at cycle 0.
- Macro off: compile without `OPERAND_TF_CTRL_PERF_EN`, rerun the backpressure test → both counters read 0 throughout.

Source files
------------

// File: rtl/operand_tf_ctrl.sv
// ----------------------------------------------------------------------------
// operand_tf_ctrl
// Sequencing and packing stage in front of the operand_tf_lane array. It takes
// one MX block per handshake, fans its elements and scales out to the lanes,
// steps the lanes through an even pass and then an odd pass, and captures the
// lane results into a valid/ready output register.
//
// Optional feature macro: OPERAND_TF_CTRL_PERF_EN (performance counters).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      input block handshake
//   in_elems, in_scales      2*NUM_LANES elements, NUM_LANES micro scales
//   lane_load                broadcast load_input (in_valid while IDLE)
//   lane_iter_sel, lane_we   broadcast iter_sel / we_result
//   lane_elem0/1, lane_scale per-lane operands sliced from the input block
//   lane_res0/1              per-lane results
//   out_valid/ready, out_data packed result register and its handshake
//   busy                     controller not in IDLE
//   perf_blk_cnt             delivered blocks (0 when counters are disabled)
//   perf_stall_cnt           DONE cycles blocked by a full output register
// ----------------------------------------------------------------------------

package operand_tf_pkg;
   localparam int unsigned ELEM_WIDTH_IN  = 8;
   localparam int unsigned ELEM_WIDTH_OUT = 16;
   localparam int unsigned SCALE_WIDTH    = 8;
endpackage

module operand_tf_ctrl #(
   parameter int unsigned NUM_LANES      = 8,
   parameter int unsigned ELEM_WIDTH_IN  = operand_tf_pkg::ELEM_WIDTH_IN,
   parameter int unsigned ELEM_WIDTH_OUT = operand_tf_pkg::ELEM_WIDTH_OUT,
   parameter int unsigned SCALE_WIDTH    = operand_tf_pkg::SCALE_WIDTH
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    in_valid,
   output logic                                    in_ready,
   input  logic [2*NUM_LANES*ELEM_WIDTH_IN-1:0]    in_elems,
   input  logic [NUM_LANES*SCALE_WIDTH-1:0]        in_scales,
   output logic                                    lane_load,
   output logic                                    lane_iter_sel,
   output logic                                    lane_we,
   output logic [NUM_LANES*ELEM_WIDTH_IN-1:0]      lane_elem0,
   output logic [NUM_LANES*ELEM_WIDTH_IN-1:0]      lane_elem1,
   output logic [NUM_LANES*SCALE_WIDTH-1:0]        lane_scale,
   input  logic [NUM_LANES*ELEM_WIDTH_OUT-1:0]     lane_res0,
   input  logic [NUM_LANES*ELEM_WIDTH_OUT-1:0]     lane_res1,
   output logic                                    out_valid,
   input  logic                                    out_ready,
   output logic [2*NUM_LANES*ELEM_WIDTH_OUT-1:0]   out_data,
   output logic                                    busy,
   output logic [31:0]                             perf_blk_cnt,
   output logic [31:0]                             perf_stall_cnt
);

   localparam int unsigned OUT_W = 2 * NUM_LANES * ELEM_WIDTH_OUT;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EVEN = 2'd1,
      ST_ODD  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t             r_state;
   logic               r_in_ready;
   logic               r_busy;
   logic               r_we;
   logic               r_iter_sel;
   logic               r_out_valid;
   logic [OUT_W-1:0]   r_out_data;
   logic [OUT_W-1:0]   w_pack;
   logic               w_out_free;

   // Lane operand fan-out: element 2i -> lane i elem_0, 2i+1 -> lane i elem_1.
   always_comb begin
      lane_elem0 = '0;
      lane_elem1 = '0;
      lane_scale = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         lane_elem0[i*ELEM_WIDTH_IN +: ELEM_WIDTH_IN] = in_elems[(2*i)*ELEM_WIDTH_IN +: ELEM_WIDTH_IN];
         lane_elem1[i*ELEM_WIDTH_IN +: ELEM_WIDTH_IN] = in_elems[(2*i+1)*ELEM_WIDTH_IN +: ELEM_WIDTH_IN];
         lane_scale[i*SCALE_WIDTH +: SCALE_WIDTH]     = in_scales[i*SCALE_WIDTH +: SCALE_WIDTH];
      end
   end

   // Result packing: word 2i = lane i res0, word 2i+1 = lane i res1.
   always_comb begin
      w_pack = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         w_pack[(2*i)*ELEM_WIDTH_OUT +: ELEM_WIDTH_OUT]   = lane_res0[i*ELEM_WIDTH_OUT +: ELEM_WIDTH_OUT];
         w_pack[(2*i+1)*ELEM_WIDTH_OUT +: ELEM_WIDTH_OUT] = lane_res1[i*ELEM_WIDTH_OUT +: ELEM_WIDTH_OUT];
      end
   end

   // Output register can take new data when empty or draining this cycle.
   assign w_out_free = !r_out_valid || out_ready;

   // Sequencer: lane controls are registered one cycle ahead of the state they belong to.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_in_ready  <= 1'b1;
         r_busy      <= 1'b0;
         r_we        <= 1'b0;
         r_iter_sel  <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else begin
         r_we       <= 1'b0;
         r_iter_sel <= 1'b0;
         if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
         end
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_state    <= ST_EVEN;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  r_we       <= 1'b1;
               end
            end
            ST_EVEN: begin
               r_state    <= ST_ODD;
               r_we       <= 1'b1;
               r_iter_sel <= 1'b1;
            end
            ST_ODD: begin
               r_state <= ST_DONE;
            end
            ST_DONE: begin
               // A reload overrides the drain above, keeping out_valid high.
               if (w_out_free) begin
                  r_out_data  <= w_pack;
                  r_out_valid <= 1'b1;
                  r_state     <= ST_IDLE;
                  r_in_ready  <= 1'b1;
                  r_busy      <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready      = r_in_ready;
   assign lane_load     = r_in_ready & in_valid;
   assign lane_iter_sel = r_iter_sel;
   assign lane_we       = r_we;
   assign out_valid     = r_out_valid;
   assign out_data      = r_out_data;
   assign busy          = r_busy;

`ifdef OPERAND_TF_CTRL_PERF_EN
   logic [31:0] r_blk_cnt;
   logic [31:0] r_stall_cnt;

   // Delivered-block and output-stall counters; both wrap modulo 2^32.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_blk_cnt   <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (r_out_valid && out_ready) begin
            r_blk_cnt <= r_blk_cnt + 32'd1;
         end
         if ((r_state == ST_DONE) && !w_out_free) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
         end
      end
   end

   assign perf_blk_cnt   = r_blk_cnt;
   assign perf_stall_cnt = r_stall_cnt;
`else
   assign perf_blk_cnt   = 32'd0;
   assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_operand_tf_ctrl.sv
// ----------------------------------------------------------------------------
// tb_operand_tf_ctrl
// Directed bench for operand_tf_ctrl driving a behavioural array of eight
// lanes, each multiplying its captured elements by its captured scale.
// ----------------------------------------------------------------------------
module tb_operand_tf_ctrl;

   localparam int unsigned NL  = 8;
   localparam int unsigned EWI = 8;
   localparam int unsigned EWO = 16;
   localparam int unsigned SW  = 8;

`ifdef OPERAND_TF_CTRL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  in_valid;
   logic                  in_ready;
   logic [2*NL*EWI-1:0]   in_elems;
   logic [NL*SW-1:0]      in_scales;
   logic                  lane_load, lane_iter_sel, lane_we;
   logic [NL*EWI-1:0]     lane_elem0, lane_elem1;
   logic [NL*SW-1:0]      lane_scale;
   logic [NL*EWO-1:0]     lane_res0, lane_res1;
   logic                  out_valid;
   logic                  out_ready;
   logic [2*NL*EWO-1:0]   out_data;
   logic                  busy;
   logic [31:0]           perf_blk_cnt, perf_stall_cnt;

   int n_vec = 0;
   int n_err = 0;
   int exp_blk = 0;
   int exp_stall = 0;

   always #5 clk = ~clk;

   operand_tf_ctrl #(.NUM_LANES(NL), .ELEM_WIDTH_IN(EWI), .ELEM_WIDTH_OUT(EWO), .SCALE_WIDTH(SW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_elems(in_elems), .in_scales(in_scales),
      .lane_load(lane_load), .lane_iter_sel(lane_iter_sel), .lane_we(lane_we),
      .lane_elem0(lane_elem0), .lane_elem1(lane_elem1), .lane_scale(lane_scale),
      .lane_res0(lane_res0), .lane_res1(lane_res1),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy), .perf_blk_cnt(perf_blk_cnt), .perf_stall_cnt(perf_stall_cnt)
   );

   // Behavioural lanes: capture on load, res0 on even write, res1 on odd write.
   logic [EWI-1:0] l_e0 [NL];
   logic [EWI-1:0] l_e1 [NL];
   logic [SW-1:0]  l_s  [NL];
   logic [EWO-1:0] l_r0 [NL];
   logic [EWO-1:0] l_r1 [NL];

   always_ff @(posedge clk) begin
      for (int i = 0; i < NL; i++) begin
         if (lane_load) begin
            l_e0[i] <= lane_elem0[i*EWI +: EWI];
            l_e1[i] <= lane_elem1[i*EWI +: EWI];
            l_s[i]  <= lane_scale[i*SW +: SW];
         end
         if (lane_we && !lane_iter_sel) l_r0[i] <= 16'(l_e0[i]) * 16'(l_s[i]);
         if (lane_we && lane_iter_sel)  l_r1[i] <= 16'(l_e1[i]) * 16'(l_s[i]);
      end
   end

   always_comb begin
      lane_res0 = '0;
      lane_res1 = '0;
      for (int i = 0; i < NL; i++) begin
         lane_res0[i*EWO +: EWO] = l_r0[i];
         lane_res1[i*EWO +: EWO] = l_r1[i];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Block with element 2i = b0+i, element 2i+1 = b1+i, all scales s.
   task automatic set_block(input int b0, input int b1, input int s);
      for (int i = 0; i < NL; i++) begin
         in_elems[(2*i)*EWI +: EWI]   = 8'(b0 + i);
         in_elems[(2*i+1)*EWI +: EWI] = 8'(b1 + i);
         in_scales[i*SW +: SW]        = 8'(s);
      end
   endtask

   function automatic logic [2*NL*EWO-1:0] exp_pack(input int b0, input int b1, input int s);
      logic [2*NL*EWO-1:0] d;
      d = '0;
      for (int i = 0; i < NL; i++) begin
         d[(2*i)*EWO +: EWO]   = 16'((b0 + i) * s);
         d[(2*i+1)*EWO +: EWO] = 16'((b1 + i) * s);
      end
      return d;
   endfunction

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_elems = '0; in_scales = '0;
      tick(); tick();
      rst = 1'b0;
      #1;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
      n_vec++; if (out_data !== '0) begin n_err++; $display("FAIL reset_out_data: got %0h exp 0", out_data); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b exp 0", busy); end
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
      n_vec++; if ({lane_we, lane_iter_sel, lane_load} !== 3'b000) begin n_err++; $display("FAIL reset_lane_ctl: got %b exp 000", {lane_we, lane_iter_sel, lane_load}); end
      n_vec++; if (perf_blk_cnt !== 32'd0) begin n_err++; $display("FAIL reset_blk_cnt: got %0d exp 0", perf_blk_cnt); end
      n_vec++; if (perf_stall_cnt !== 32'd0) begin n_err++; $display("FAIL reset_stall_cnt: got %0d exp 0", perf_stall_cnt); end
      exp_blk = 0; exp_stall = 0;
   endtask

   task automatic test_single();
      logic [2*NL*EWO-1:0] e;
      e = exp_pack(1, 17, 3);
      for (int c = 0; c < 6; c++) begin
         tick();
         in_valid = (c == 0); out_ready = 1'b1;
         if (c == 0) set_block(1, 17, 3);
         #1;
         case (c)
            0: begin
               n_vec++; if (lane_load !== 1'b1) begin n_err++; $display("FAIL single_load: got %b exp 1", lane_load); end
               n_vec++; if (lane_elem0[3*EWI +: EWI] !== 8'd4) begin n_err++; $display("FAIL single_elem0_l3: got %0d exp 4", lane_elem0[3*EWI +: EWI]); end
               n_vec++; if (lane_elem1[3*EWI +: EWI] !== 8'd20) begin n_err++; $display("FAIL single_elem1_l3: got %0d exp 20", lane_elem1[3*EWI +: EWI]); end
               n_vec++; if (lane_scale[7*SW +: SW] !== 8'd3) begin n_err++; $display("FAIL single_scale_l7: got %0d exp 3", lane_scale[7*SW +: SW]); end
            end
            1: begin
               n_vec++; if ({lane_we, lane_iter_sel} !== 2'b10) begin n_err++; $display("FAIL single_even: got we/sel %b exp 10", {lane_we, lane_iter_sel}); end
               n_vec++; if ({in_ready, lane_load, busy} !== 3'b001) begin n_err++; $display("FAIL single_even_hs: got rdy/load/busy %b exp 001", {in_ready, lane_load, busy}); end
            end
            2: begin
               n_vec++; if ({lane_we, lane_iter_sel} !== 2'b11) begin n_err++; $display("FAIL single_odd: got we/sel %b exp 11", {lane_we, lane_iter_sel}); end
            end
            3: begin
               n_vec++; if ({lane_we, lane_iter_sel, out_valid, busy} !== 4'b0001) begin n_err++; $display("FAIL single_done: got we/sel/ov/busy %b exp 0001", {lane_we, lane_iter_sel, out_valid, busy}); end
            end
            4: begin
               n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_out_valid: got %b exp 1", out_valid); end
               n_vec++; if (out_data !== e) begin n_err++; $display("FAIL single_out_data: got %h exp %h", out_data, e); end
               n_vec++; if ({in_ready, busy} !== 2'b10) begin n_err++; $display("FAIL single_idle: got rdy/busy %b exp 10", {in_ready, busy}); end
               exp_blk++;
            end
            default: begin
               n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_drain: got %b exp 0", out_valid); end
               n_vec++; if (perf_blk_cnt !== 32'(PERF ? exp_blk : 0)) begin n_err++; $display("FAIL single_blk_cnt: got %0d exp %0d", perf_blk_cnt, PERF ? exp_blk : 0); end
            end
         endcase
      end
   endtask

   task automatic test_back_to_back();
      logic [2*NL*EWO-1:0] e;
      for (int c = 0; c < 14; c++) begin
         tick();
         in_valid = (c <= 8); out_ready = 1'b1;
         if (c % 4 == 0 && c <= 8) set_block(10 + 20*(c/4), 50 + 20*(c/4), 2 + c/4);
         #1;
         n_vec++; if (lane_load !== (c % 4 == 0 && c <= 8)) begin n_err++; $display("FAIL b2b_load c%0d: got %b", c, lane_load); end
         if (c >= 1) begin
            n_vec++; if (out_valid !== (c >= 4 && c % 4 == 0)) begin n_err++; $display("FAIL b2b_out_valid c%0d: got %b", c, out_valid); end
         end
         if (c >= 4 && c % 4 == 0) begin
            e = exp_pack(10 + 20*(c/4 - 1), 50 + 20*(c/4 - 1), 2 + c/4 - 1);
            n_vec++; if (out_data !== e) begin n_err++; $display("FAIL b2b_data c%0d: got %h exp %h", c, out_data, e); end
            exp_blk++;
         end
      end
      n_vec++; if (perf_blk_cnt !== 32'(PERF ? exp_blk : 0)) begin n_err++; $display("FAIL b2b_blk_cnt: got %0d exp %0d", perf_blk_cnt, PERF ? exp_blk : 0); end
   endtask

   task automatic test_perturb();
      logic [2*NL*EWO-1:0] e;
      e = exp_pack(5, 40, 7);
      for (int c = 0; c < 6; c++) begin
         tick();
         in_valid = (c <= 3); out_ready = 1'b1;
         if (c == 0) set_block(5, 40, 7);
         if (c == 1) in_elems = '1;
         #1;
         if (c == 4) begin
            n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL perturb_valid: got %b exp 1", out_valid); end
            n_vec++; if (out_data !== e) begin n_err++; $display("FAIL perturb_data: got %h exp %h", out_data, e); end
            exp_blk++;
         end
         if (c == 5) begin
            n_vec++; if ({out_valid, busy} !== 2'b00) begin n_err++; $display("FAIL perturb_idle: got ov/busy %b exp 00", {out_valid, busy}); end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [2*NL*EWO-1:0] ea, eb;
      ea = exp_pack(2, 30, 5);
      eb = exp_pack(9, 60, 6);
      for (int c = 0; c < 15; c++) begin
         tick();
         in_valid = (c == 0 || c == 4); out_ready = (c >= 12);
         if (c == 0) set_block(2, 30, 5);
         if (c == 4) set_block(9, 60, 6);
         #1;
         if (c >= 4 && c <= 12) begin
            n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid c%0d: got %b exp 1", c, out_valid); end
            n_vec++; if (out_data !== ea) begin n_err++; $display("FAIL bp_hold_data c%0d: got %h exp %h", c, out_data, ea); end
         end
         if (c >= 7 && c <= 12) begin
            n_vec++; if ({busy, in_ready, lane_we} !== 3'b100) begin n_err++; $display("FAIL bp_done c%0d: got busy/rdy/we %b exp 100", c, {busy, in_ready, lane_we}); end
            n_vec++; if (perf_stall_cnt !== 32'(PERF ? exp_stall : 0)) begin n_err++; $display("FAIL bp_stall_cnt c%0d: got %0d exp %0d", c, perf_stall_cnt, PERF ? exp_stall : 0); end
            if (c <= 11) exp_stall++;
         end
         if (c == 12) exp_blk++;
         if (c == 13) begin
            n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_second_valid: got %b exp 1", out_valid); end
            n_vec++; if (out_data !== eb) begin n_err++; $display("FAIL bp_second_data: got %h exp %h", out_data, eb); end
            n_vec++; if (perf_blk_cnt !== 32'(PERF ? exp_blk : 0)) begin n_err++; $display("FAIL bp_blk_cnt: got %0d exp %0d", perf_blk_cnt, PERF ? exp_blk : 0); end
            n_vec++; if (perf_stall_cnt !== 32'(PERF ? exp_stall : 0)) begin n_err++; $display("FAIL bp_stall_final: got %0d exp %0d", perf_stall_cnt, PERF ? exp_stall : 0); end
            exp_blk++;
         end
         if (c == 14) begin
            n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain: got %b exp 0", out_valid); end
         end
      end
   endtask

   task automatic test_reset_in_odd();
      for (int c = 0; c < 8; c++) begin
         tick();
         in_valid = (c == 0); out_ready = 1'b1; rst = (c == 2);
         if (c == 0) set_block(1, 2, 9);
         #1;
         if (c == 2) begin
            n_vec++; if (lane_iter_sel !== 1'b1) begin n_err++; $display("FAIL rodd_in_odd: got sel %b exp 1", lane_iter_sel); end
         end
         if (c == 3) begin
            exp_blk = 0; exp_stall = 0;
            n_vec++; if ({busy, in_ready, out_valid, lane_we, lane_iter_sel} !== 5'b01000) begin n_err++; $display("FAIL rodd_idle: got busy/rdy/ov/we/sel %b exp 01000", {busy, in_ready, out_valid, lane_we, lane_iter_sel}); end
            n_vec++; if (out_data !== '0) begin n_err++; $display("FAIL rodd_data: got %h exp 0", out_data); end
            n_vec++; if ({perf_blk_cnt, perf_stall_cnt} !== 64'd0) begin n_err++; $display("FAIL rodd_cnt: got %0d/%0d exp 0/0", perf_blk_cnt, perf_stall_cnt); end
         end
         if (c >= 4) begin
            n_vec++; if ({out_valid, busy} !== 2'b00) begin n_err++; $display("FAIL rodd_no_output c%0d: got ov/busy %b exp 00", c, {out_valid, busy}); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_perturb();
      test_backpressure();
      test_reset_in_odd();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
